if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/if_fetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_fetch_pkg : constants and types for the instruction fetch stage |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
package if_fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo : 2-entry {pc, inst} buffer between fetch and decode    |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module fetch_fifo
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  input  logic        pop,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output logic [1:0]  count,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst
);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_pop  = pop && (r_count != 2'd0);
  // A push into a full buffer is only accepted when a pop frees a slot.
  assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '{pc: 32'h0, inst: NOP_INST};
      r_mem[1] <= '{pc: 32'h0, inst: NOP_INST};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= '{pc: push_pc, inst: push_inst};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign full      = (r_count == 2'd2);
  assign empty     = (r_count == 2'd0);
  assign count     = r_count;
  assign head_pc   = r_mem[r_rd_ptr].pc;
  assign head_inst = r_mem[r_rd_ptr].inst;

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_fetch : instruction fetch with single-outstanding imem handshake |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_req_pc, w_req_pc_nxt;
  logic [31:0]  r_hold_addr, w_hold_addr_nxt;
  logic         r_hold, w_hold_nxt;
  logic         r_hold_drop, w_hold_drop_nxt;
  logic         r_run;
  logic [31:0]  r_last_pc;
  logic         w_push, w_pop, w_full, w_empty;
  logic [1:0]   w_count;
  logic [31:0]  w_head_pc, w_head_inst, w_redirect_pc;
  logic         w_unused_pc_lsb;

  assign w_redirect_pc   = {redirect_pc_i[31:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  // r_run keeps the request low until the first edge after reset release.
  assign imem_req_o  = r_run && (r_state == S_IDLE) && !w_full &&
                       ({30'd0, w_count} < FIFO_DEPTH[31:0]);
  // A request left waiting for grant keeps its address even if redirected.
  assign imem_addr_o = r_hold ? r_hold_addr : r_pc;

  assign w_push = (r_state == S_WAIT) && imem_rvalid_i && !redirect_i;
  assign w_pop  = !w_empty && !stall_i && !redirect_i;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_pc_nxt    = r_req_pc;
    w_hold_nxt      = r_hold;
    w_hold_drop_nxt = r_hold_drop;
    w_hold_addr_nxt = r_hold_addr;
    if (redirect_i) begin
      w_pc_nxt = w_redirect_pc;
    end
    case (r_state)
      S_IDLE: begin
        if (imem_req_o && imem_gnt_i) begin
          w_hold_nxt      = 1'b0;
          w_hold_drop_nxt = 1'b0;
          if (redirect_i || r_hold_drop) begin
            w_state_nxt = S_DROP;
          end else begin
            w_state_nxt  = S_WAIT;
            w_req_pc_nxt = imem_addr_o;
            w_pc_nxt     = r_pc + 32'd4;
          end
        end else if (imem_req_o) begin
          w_hold_nxt      = 1'b1;
          w_hold_addr_nxt = imem_addr_o;
          if (redirect_i) begin
            w_hold_drop_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          w_state_nxt = S_IDLE;
        end else if (redirect_i) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_hold      <= 1'b0;
      r_hold_drop <= 1'b0;
      r_hold_addr <= RESET_PC;
      r_run       <= 1'b0;
      r_last_pc   <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_drop <= w_hold_drop_nxt;
      r_hold_addr <= w_hold_addr_nxt;
      r_run       <= 1'b1;
      if (!w_empty) begin
        r_last_pc <= w_head_pc;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_pc   (r_req_pc),
    .push_inst (imem_rdata_i),
    .pop       (w_pop),
    .flush     (redirect_i),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head_pc   (w_head_pc),
    .head_inst (w_head_inst)
  );

  assign valid_o = !w_empty;
  assign pc_o    = w_empty ? r_last_pc : w_head_pc;
  assign inst_o  = w_empty ? NOP_INST : w_head_inst;

endmodule
`default_nettype wire
